// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, imem handshake and IF/ID register.
// Optional architectural branch delay slot is enabled by defining DELAY_SLOT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [2:0]  i_redirect_sel,
  input  logic [31:0] i_redirect_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc_plus4,
  output logic        o_ifid_valid
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_DROP  = 1'b1;

`ifdef DELAY_SLOT_EN
  localparam bit C_SLOT_EN = 1'b1;
`else
  localparam bit C_SLOT_EN = 1'b0;
`endif

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_pend_slot;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc_plus4;
  logic        r_ifid_valid;

  logic [0:0]  w_nxt_state;
  logic [31:0] w_nxt_pc;
  logic [31:0] w_nxt_pend_pc;
  logic        w_nxt_pend_slot;
  logic [31:0] w_nxt_ifid_instr;
  logic [31:0] w_nxt_ifid_pc_plus4;
  logic        w_nxt_ifid_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redir_pc;
  logic        w_sel_flow;
  logic        w_sel_trap;
  logic        w_take;
  logic        w_trap_take;
  logic [31:0] w_drop_pc;
  logic        w_drop_slot;

  // Incrementing never touches the supervisor bit; wrap stays inside the half.
  assign w_pc_plus4 = {r_pc[31], r_pc[30:0] + 31'd4};

  assign w_sel_flow  = (i_redirect_sel == 3'd1) || (i_redirect_sel == 3'd2) ||
                       (i_redirect_sel == 3'd3);
  assign w_sel_trap  = (i_redirect_sel == 3'd4) || (i_redirect_sel == 3'd5);
  assign w_take      = i_redirect_valid && (w_sel_flow || w_sel_trap);
  assign w_trap_take = i_redirect_valid && w_sel_trap;

  always_comb begin
    w_redir_pc = i_redirect_target;
    case (i_redirect_sel)
      3'd1, 3'd2: w_redir_pc = {r_ifid_pc_plus4[31], i_redirect_target[30:0]};
      3'd4:       w_redir_pc = ILLOP_VEC;
      3'd5:       w_redir_pc = XADR_VEC;
      default:    w_redir_pc = i_redirect_target;
    endcase
  end

  // While draining a fetch only traps may replace the pending target.
  assign w_drop_pc   = w_trap_take ? w_redir_pc : r_pend_pc;
  assign w_drop_slot = w_trap_take ? 1'b0 : r_pend_slot;

  always_comb begin
    w_nxt_state         = r_state;
    w_nxt_pc            = r_pc;
    w_nxt_pend_pc       = r_pend_pc;
    w_nxt_pend_slot     = r_pend_slot;
    w_nxt_ifid_instr    = r_ifid_instr;
    w_nxt_ifid_pc_plus4 = r_ifid_pc_plus4;
    w_nxt_ifid_valid    = r_ifid_valid;

    case (r_state)
      S_FETCH: begin
        if (w_take) begin
          w_nxt_ifid_instr = 32'h0;
          w_nxt_ifid_valid = 1'b0;
          if (i_imem_ready) begin
            w_nxt_pc = w_redir_pc;
            if (C_SLOT_EN && w_sel_flow) begin
              w_nxt_ifid_instr    = i_imem_rdata;
              w_nxt_ifid_pc_plus4 = w_pc_plus4;
              w_nxt_ifid_valid    = 1'b1;
            end
          end else begin
            w_nxt_pend_pc   = w_redir_pc;
            w_nxt_pend_slot = w_sel_flow;
            w_nxt_state     = S_DROP;
          end
        end else if (!i_stall) begin
          if (i_imem_ready) begin
            w_nxt_ifid_instr    = i_imem_rdata;
            w_nxt_ifid_pc_plus4 = w_pc_plus4;
            w_nxt_ifid_valid    = 1'b1;
            w_nxt_pc            = w_pc_plus4;
          end else begin
            w_nxt_ifid_instr = 32'h0;
            w_nxt_ifid_valid = 1'b0;
          end
        end
      end

      S_DROP: begin
        w_nxt_ifid_instr = 32'h0;
        w_nxt_ifid_valid = 1'b0;
        if (i_imem_ready) begin
          w_nxt_pc    = w_drop_pc;
          w_nxt_state = S_FETCH;
          if (C_SLOT_EN && w_drop_slot) begin
            w_nxt_ifid_instr    = i_imem_rdata;
            w_nxt_ifid_pc_plus4 = w_pc_plus4;
            w_nxt_ifid_valid    = 1'b1;
          end
        end else begin
          w_nxt_pend_pc   = w_drop_pc;
          w_nxt_pend_slot = w_drop_slot;
        end
      end

      default: w_nxt_state = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state         <= S_FETCH;
      r_pc            <= RESET_VEC;
      r_pend_pc       <= 32'h0;
      r_pend_slot     <= 1'b0;
      r_ifid_instr    <= 32'h0;
      r_ifid_pc_plus4 <= 32'h0;
      r_ifid_valid    <= 1'b0;
    end else begin
      r_state         <= w_nxt_state;
      r_pc            <= w_nxt_pc;
      r_pend_pc       <= w_nxt_pend_pc;
      r_pend_slot     <= w_nxt_pend_slot;
      r_ifid_instr    <= w_nxt_ifid_instr;
      r_ifid_pc_plus4 <= w_nxt_ifid_pc_plus4;
      r_ifid_valid    <= w_nxt_ifid_valid;
    end
  end

  // Requests are suppressed for as long as reset is held low.
  assign o_imem_req      = i_reset;
  assign o_imem_addr     = r_pc;
  assign o_pc            = r_pc;
  assign o_ifid_instr    = r_ifid_instr;
  assign o_ifid_pc_plus4 = r_ifid_pc_plus4;
  assign o_ifid_valid    = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic against a reference model.
// Honours DELAY_SLOT_EN the same way the design does.
module tb_fetch_stage;

`ifdef DELAY_SLOT_EN
  localparam bit SLOT = 1'b1;
`else
  localparam bit SLOT = 1'b0;
`endif
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        stall = 1'b0;
  logic        redirValid = 1'b0;
  logic [2:0]  redirSel = 3'd0;
  logic [31:0] redirTarget = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata = 32'h0;
  logic        imemReady = 1'b0;
  logic [31:0] pc;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state, described in terms of the architectural behaviour.
  logic [31:0] mPc;
  logic        mDraining;
  logic [31:0] mPendPc;
  logic        mPendSlot;
  logic [31:0] mInstr;
  logic [31:0] mPcPlus4;
  logic        mValid;

  fetch_stage dut (
    .i_clk             (clk),
    .i_reset           (resetN),
    .i_stall           (stall),
    .i_redirect_valid  (redirValid),
    .i_redirect_sel    (redirSel),
    .i_redirect_target (redirTarget),
    .o_imem_req        (imemReq),
    .o_imem_addr       (imemAddr),
    .i_imem_rdata      (imemRdata),
    .i_imem_ready      (imemReady),
    .o_pc              (pc),
    .o_ifid_instr      (ifidInstr),
    .o_ifid_pc_plus4   (ifidPcPlus4),
    .o_ifid_valid      (ifidValid)
  );

  always #5 clk = ~clk;

  // Memory contents: a nonzero hash of the address so bubbles are distinguishable.
  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return ((a * 32'h9E37_79B1) ^ 32'h1234_5670) | 32'h1;
  endfunction

  function automatic logic [31:0] plus4(input logic [31:0] a);
    return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  // Drives one cycle of inputs, advances the model, and returns 1 time unit after the edge.
  task automatic tick(input logic rst, input logic st, input logic rv, input logic [2:0] sel,
                      input logic [31:0] tgt, input logic rdy);
    logic        flow, trap, take;
    logic [31:0] target;
    resetN = rst; stall = st; redirValid = rv; redirSel = sel; redirTarget = tgt;
    imemReady = rdy; imemRdata = instrOf(imemAddr);
    flow = rv && (sel >= 3'd1) && (sel <= 3'd3);
    trap = rv && (sel == 3'd4 || sel == 3'd5);
    take = flow || trap;
    if (sel == 3'd4)      target = ILLOP_VEC;
    else if (sel == 3'd5) target = XADR_VEC;
    else if (sel == 3'd3) target = tgt;
    else                  target = {mPcPlus4[31], tgt[30:0]};
    if (!rst) begin
      mPc = RESET_VEC; mDraining = 0; mPendPc = 0; mPendSlot = 0;
      mInstr = 0; mPcPlus4 = 0; mValid = 0;
    end else if (mDraining) begin
      if (trap) begin mPendPc = target; mPendSlot = 0; end
      if (rdy && SLOT && mPendSlot) begin
        mInstr = instrOf(mPc); mPcPlus4 = plus4(mPc); mValid = 1;
      end else begin
        mInstr = 0; mValid = 0;
      end
      if (rdy) begin mPc = mPendPc; mDraining = 0; end
    end else if (take) begin
      if (rdy && SLOT && flow) begin
        mInstr = instrOf(mPc); mPcPlus4 = plus4(mPc); mValid = 1;
      end else begin
        mInstr = 0; mValid = 0;
      end
      if (rdy) mPc = target;
      else begin mDraining = 1; mPendPc = target; mPendSlot = flow; end
    end else if (!st) begin
      if (rdy) begin
        mInstr = instrOf(mPc); mPcPlus4 = plus4(mPc); mValid = 1; mPc = plus4(mPc);
      end else begin
        mInstr = 0; mValid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 3'd0, 32'h0, 1);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 3'd0, 32'h0, 1);
      nChecks++; if (imemReq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_req: got %b want 0", imemReq); end
      nChecks++; if (pc !== RESET_VEC) begin nFails++; $display("[TB] FAIL reset_pc: got %h want %h", pc, RESET_VEC); end
      nChecks++; if (ifidValid !== 1'b0 || ifidInstr !== 32'h0 || ifidPcPlus4 !== 32'h0) begin
        nFails++; $display("[TB] FAIL reset_ifid: got v=%b i=%h p=%h want 0/0/0", ifidValid, ifidInstr, ifidPcPlus4);
      end
    end
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (imemReq !== 1'b1) begin nFails++; $display("[TB] FAIL first_req: got %b want 1", imemReq); end
    nChecks++; if (ifidInstr !== instrOf(32'h8000_0000) || ifidPcPlus4 !== 32'h8000_0004 || ifidValid !== 1'b1) begin
      nFails++; $display("[TB] FAIL first_fetch: got i=%h p=%h v=%b want i=%h p=80000004 v=1", ifidInstr, ifidPcPlus4, ifidValid, instrOf(32'h8000_0000));
    end
    nChecks++; if (imemAddr !== 32'h8000_0004) begin nFails++; $display("[TB] FAIL second_addr: got %h want 80000004", imemAddr); end
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (imemAddr !== 32'h8000_0008 || ifidPcPlus4 !== 32'h8000_0008) begin
      nFails++; $display("[TB] FAIL third_addr: got a=%h p=%h want 80000008/80000008", imemAddr, ifidPcPlus4);
    end
  endtask

  task automatic test_wait_states;
    run(2);
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 3'd0, 32'h0, 0);
      nChecks++; if (imemAddr !== 32'h8000_0010 || ifidValid !== 1'b0) begin
        nFails++; $display("[TB] FAIL wait_hold: got a=%h v=%b want 80000010/0", imemAddr, ifidValid);
      end
    end
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (ifidValid !== 1'b1 || ifidPcPlus4 !== 32'h8000_0014 || ifidInstr !== instrOf(32'h8000_0010)) begin
      nFails++; $display("[TB] FAIL wait_done: got v=%b p=%h i=%h want 1/80000014/%h", ifidValid, ifidPcPlus4, ifidInstr, instrOf(32'h8000_0010));
    end
  endtask

  task automatic test_jump;
    tick(1, 0, 1, 3'd6, 32'h0000_0999, 1);
    nChecks++; if (imemAddr !== 32'h8000_0018) begin nFails++; $display("[TB] FAIL sel6_ignored: got %h want 80000018", imemAddr); end
    run(2);
    tick(1, 0, 1, 3'd2, 32'h0000_0400, 1);
    nChecks++; if (imemAddr !== 32'h8000_0400) begin nFails++; $display("[TB] FAIL jump_addr: got %h want 80000400", imemAddr); end
    nChecks++; if (ifidValid !== SLOT || ifidInstr !== (SLOT ? instrOf(32'h8000_0020) : 32'h0)) begin
      nFails++; $display("[TB] FAIL jump_slot: got v=%b i=%h want v=%b", ifidValid, ifidInstr, SLOT);
    end
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (ifidPcPlus4 !== 32'h8000_0404 || ifidValid !== 1'b1) begin
      nFails++; $display("[TB] FAIL jump_target_fetch: got p=%h v=%b want 80000404/1", ifidPcPlus4, ifidValid);
    end
  endtask

  task automatic test_redirect_mid_wait;
    tick(1, 0, 1, 3'd3, 32'h0000_0100, 0);
    tick(1, 0, 0, 3'd0, 32'h0, 0);
    nChecks++; if (imemAddr !== 32'h8000_0404) begin nFails++; $display("[TB] FAIL drop_addr_hold: got %h want 80000404", imemAddr); end
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (imemAddr !== 32'h0000_0100) begin nFails++; $display("[TB] FAIL drop_target: got %h want 00000100", imemAddr); end
    nChecks++; if (ifidValid !== SLOT) begin nFails++; $display("[TB] FAIL drop_slot: got %b want %b", ifidValid, SLOT); end
    run(1);
    tick(1, 0, 1, 3'd3, 32'h0000_0200, 0);
    tick(1, 0, 1, 3'd4, 32'h0, 0);
    tick(1, 0, 1, 3'd2, 32'h0000_0300, 0);
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (imemAddr !== ILLOP_VEC || ifidValid !== 1'b0) begin
      nFails++; $display("[TB] FAIL drop_irq: got a=%h v=%b want %h/0", imemAddr, ifidValid, ILLOP_VEC);
    end
  endtask

  task automatic test_stall;
    logic [31:0] heldInstr;
    tick(0, 0, 0, 3'd0, 32'h0, 1);
    run(16);
    heldInstr = instrOf(32'h8000_003C);
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 0, 3'd0, 32'h0, 1);
      nChecks++; if (pc !== 32'h8000_0040 || ifidInstr !== heldInstr || ifidPcPlus4 !== 32'h8000_0040 || ifidValid !== 1'b1) begin
        nFails++; $display("[TB] FAIL stall_hold: got pc=%h i=%h p=%h v=%b want 80000040/%h/80000040/1", pc, ifidInstr, ifidPcPlus4, ifidValid, heldInstr);
      end
    end
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (ifidInstr !== instrOf(32'h8000_0040) || ifidPcPlus4 !== 32'h8000_0044) begin
      nFails++; $display("[TB] FAIL stall_refetch: got i=%h p=%h want %h/80000044", ifidInstr, ifidPcPlus4, instrOf(32'h8000_0040));
    end
    tick(1, 1, 1, 3'd2, 32'h0000_0600, 1);
    nChecks++; if (imemAddr !== 32'h8000_0600) begin nFails++; $display("[TB] FAIL stall_vs_redirect: got %h want 80000600", imemAddr); end
  endtask

  task automatic test_reset_mid_drop;
    tick(1, 0, 1, 3'd5, 32'h0, 0);
    tick(0, 0, 0, 3'd0, 32'h0, 0);
    nChecks++; if (pc !== RESET_VEC || ifidValid !== 1'b0 || imemReq !== 1'b0) begin
      nFails++; $display("[TB] FAIL drop_reset: got pc=%h v=%b req=%b want %h/0/0", pc, ifidValid, imemReq, RESET_VEC);
    end
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (imemAddr !== 32'h8000_0004 || ifidPcPlus4 !== 32'h8000_0004 || ifidValid !== 1'b1) begin
      nFails++; $display("[TB] FAIL drop_reset_resume: got a=%h p=%h v=%b want 80000004/80000004/1", imemAddr, ifidPcPlus4, ifidValid);
    end
  endtask

  task automatic test_pc_wrap;
    tick(1, 0, 1, 3'd3, 32'hFFFF_FFFC, 1);
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (pc !== 32'h8000_0000 || ifidPcPlus4 !== 32'h8000_0000) begin
      nFails++; $display("[TB] FAIL wrap_super: got pc=%h p=%h want 80000000/80000000", pc, ifidPcPlus4);
    end
    tick(1, 0, 1, 3'd3, 32'h7FFF_FFFC, 1);
    tick(1, 0, 0, 3'd0, 32'h0, 1);
    nChecks++; if (pc !== 32'h0000_0000 || ifidPcPlus4 !== 32'h0000_0000) begin
      nFails++; $display("[TB] FAIL wrap_user: got pc=%h p=%h want 0/0", pc, ifidPcPlus4);
    end
    tick(1, 0, 1, 3'd1, 32'h8000_0500, 1);
    nChecks++; if (pc !== 32'h0000_0500) begin nFails++; $display("[TB] FAIL branch_keeps_user: got %h want 00000500", pc); end
  endtask

  task automatic test_random;
    logic rst, st, rv, rdy;
    logic [2:0] sel;
    logic [31:0] tgt;
    tick(0, 0, 0, 3'd0, 32'h0, 1);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) != 0);
      st  = ($urandom_range(0, 4) == 0);
      rv  = ($urandom_range(0, 5) == 0);
      sel = 3'($urandom_range(0, 7));
      tgt = $urandom() & 32'hFFFF_FFFC;
      rdy = ($urandom_range(0, 2) != 0);
      tick(rst, st, rv, sel, tgt, rdy);
      nChecks++; if (pc !== mPc || imemAddr !== mPc) begin
        nFails++; $display("[TB] FAIL rand_pc cycle %0d: got pc=%h a=%h want %h", i, pc, imemAddr, mPc);
      end
      nChecks++; if (imemReq !== rst) begin nFails++; $display("[TB] FAIL rand_req cycle %0d: got %b want %b", i, imemReq, rst); end
      nChecks++; if (ifidValid !== mValid || ifidInstr !== mInstr) begin
        nFails++; $display("[TB] FAIL rand_ifid cycle %0d: got v=%b i=%h want v=%b i=%h", i, ifidValid, ifidInstr, mValid, mInstr);
      end
      if (mValid) begin
        nChecks++; if (ifidPcPlus4 !== mPcPlus4) begin
          nFails++; $display("[TB] FAIL rand_pcplus4 cycle %0d: got %h want %h", i, ifidPcPlus4, mPcPlus4);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] fetch_stage bench start, delay slot = %0d", SLOT);
    test_reset;
    test_wait_states;
    test_jump;
    test_redirect_mid_wait;
    test_stall;
    test_reset_mid_drop;
    test_pc_wrap;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
